// File: rtl/kuz_pkg.sv
// Shared Kuznyechik definitions: block geometry, S-layer sequencer states
// and a byte-slice helper.
package kuz_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } kuz_fsm_e;

  // Byte idx of a block; byte 0 is the least significant byte.
  function automatic logic [7:0] byte_slice(input logic [BLOCK_W-1:0] blk,
                                            input logic [3:0]         idx);
    return blk[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/table_convertion.sv
// Kuznyechik pi substitution: purely combinational 8-bit lookup.
module table_convertion (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  assign dout = PI[din];

endmodule

// File: rtl/kuz_s_layer_seq.sv
// Kuznyechik S-layer sequencer: substitutes a 128-bit block LANES bytes per
// cycle through shared pi lookups, with valid/ready on both sides.
module kuz_s_layer_seq
  import kuz_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned BEATS = BYTES / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("kuz_s_layer_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  kuz_fsm_e           fsm, fsm_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];
  logic               last_beat;

  assign last_beat = (cnt == CW'(BEATS - 1));
  assign out_data  = state_q;

  // Lane mux: lane j looks at byte cnt*LANES+j of the working block.
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_in[j] = byte_slice(state_q, 4'((32'(cnt) * LANES) + j));
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    table_convertion u_pi (
      .din  (lane_in[j]),
      .dout (lane_out[j])
    );
  end

  // Next-state, beat write-back and handshake outputs.
  always_comb begin
    fsm_d     = fsm;
    cnt_d     = cnt;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Write-back decoded per beat so every part-select stays constant.
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (cnt == CW'(k)) begin
            for (int unsigned j = 0; j < LANES; j++) begin
              state_d[((k * LANES) + j) * 8 +: 8] = lane_out[j];
            end
          end
        end
        if (last_beat) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_d = in_data;
            cnt_d   = '0;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  // State, beat counter and working block registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      cnt     <= '0;
      state_q <= '0;
    end else begin
      fsm     <= fsm_d;
      cnt     <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_kuz_s_layer_seq.sv
// Directed bench for kuz_s_layer_seq at LANES = 2, 1, 4 and 16.
module tb_kuz_s_layer_seq;

  localparam int NDUT = 4;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  localparam logic [127:0] VEC_IN  = 128'hffeeddccbbaa99881122334455667700;
  localparam logic [127:0] VEC_OUT = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
  localparam logic [127:0] ONES_IN = {16{8'h01}};
  localparam logic [127:0] ONES_OUT = {16{8'hee}};
  localparam logic [127:0] ZERO_OUT = {16{8'hfc}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_data   [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_data  [NDUT];
  logic         busy      [NDUT];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;
    kuz_s_layer_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 9 : (g == 1) ? 17 : (g == 2) ? 5 : 2;
  endfunction

  function automatic logic [127:0] pi_block(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = PI[b[i*8 +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Hand one block to DUT g, then wait for its result and check latency/data.
  task automatic send_measure(input int g, input logic [127:0] d, input logic [127:0] exp,
                              input string tag);
    int n;
    int lat;
    @(negedge clk);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    #1;
    n = 0;
    while (!in_ready[g] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_accept"}, 128'(in_ready[g]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[g] = 1'b0;
    in_data[g]  = '0;
    #1;
    check({tag, "_busy"}, 128'(busy[g]), 128'(1));
    lat = 1;
    while (!out_valid[g] && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(lat_of(g)));
    check({tag, "_data"}, out_data[g], exp);
  endtask

  // Take the pending output of DUT g and confirm it returns to idle.
  task automatic drain(input int g, input string tag);
    out_ready[g] = 1'b1;
    #1;
    check({tag, "_rdy_done"}, 128'(in_ready[g]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    out_ready[g] = 1'b0;
    #1;
    check({tag, "_vld_clr"}, 128'(out_valid[g]), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] blk     [64];
    logic [127:0] exp_blk [64];
    int lat, sent, recv, cyc, last;
    logic hs;

    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready[0]), 128'(0));
    check("rst_out_valid", 128'(out_valid[0]), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("post_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("post_rst_out_data", out_data[0], '0);
    check("post_rst_busy", 128'(busy[0]), 128'(0));
    check("post_rst_out_data16", out_data[3], '0);

    // Reference vector at LANES=2.
    send_measure(0, VEC_IN, VEC_OUT, "vec");
    drain(0, "vec");

    // Uniform blocks on every lane count.
    for (int g = 0; g < NDUT; g++) begin
      send_measure(g, '0, ZERO_OUT, $sformatf("zero%0d", g));
      drain(g, $sformatf("zero%0d", g));
      send_measure(g, ONES_IN, ONES_OUT, $sformatf("ones%0d", g));
      drain(g, $sformatf("ones%0d", g));
    end

    // Backpressure, then back-to-back accept.
    send_measure(0, VEC_IN, VEC_OUT, "bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("bp_hold_data", out_data[0], VEC_OUT);
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1));
      check("bp_hold_in_ready", 128'(in_ready[0]), 128'(0));
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = ONES_IN;
    #1;
    check("b2b_in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    #1;
    check("b2b_busy", 128'(busy[0]), 128'(1));
    check("b2b_out_valid", 128'(out_valid[0]), 128'(0));
    lat = 1;
    while (!out_valid[0] && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check("b2b_lat", 128'(lat), 128'(9));
    check("b2b_data", out_data[0], ONES_OUT);
    drain(0, "b2b");

    // Reset in the middle of RUN abandons the block.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 128'h0123456789abcdeffedcba9876543210;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready[0]), 128'(0));
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out_valid2", 128'(out_valid[0]), 128'(0));
    check("midrst_out_data", out_data[0], '0);
    check("midrst_busy", 128'(busy[0]), 128'(0));
    rst = 1'b0;
    send_measure(0, VEC_IN, VEC_OUT, "after_rst");
    drain(0, "after_rst");

    // Streaming with out_ready tied high.
    for (int i = 0; i < 64; i++) begin
      blk[i]     = {$urandom, $urandom, $urandom, $urandom};
      exp_blk[i] = pi_block(blk[i]);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = blk[0];
    sent = 0; recv = 0; cyc = 0; last = 0;
    while (recv < 64 && cyc < 2000) begin
      #1;
      if (out_valid[0]) begin
        check($sformatf("stream_data%0d", recv), out_data[0], exp_blk[recv]);
        if (recv > 0) check("stream_period", 128'(cyc - last), 128'(9));
        last = cyc;
        recv++;
      end
      hs = in_valid[0] && in_ready[0];
      @(negedge clk);
      cyc++;
      if (hs) begin
        sent++;
        if (sent < 64) in_data[0] = blk[sent];
        else in_valid[0] = 1'b0;
      end
    end
    check("stream_count", 128'(recv), 128'(64));
    out_ready[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
